// File: rtl/window3x3_if.sv
// Stream interface between the pixel source and the 3x3 window generator:
// pixel input side plus the nine window taps and their position/strobe outputs.
interface window3x3_if #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic                 start;
    logic                 in_valid;
    logic signed [9:0]    in_pix;

    logic                 win_valid;
    logic                 frame_done;
    logic [RW-1:0]        out_row;
    logic [CW-1:0]        out_col;
    logic signed [9:0]    x0_0, x0_1, x0_2;
    logic signed [9:0]    x1_0, x1_1, x1_2;
    logic signed [9:0]    x2_0, x2_1, x2_2;

    // Pixel source / window consumer side
    modport master (
        output start, in_valid, in_pix,
        input  win_valid, frame_done, out_row, out_col,
        input  x0_0, x0_1, x0_2, x1_0, x1_1, x1_2, x2_0, x2_1, x2_2
    );

    // Window generator side
    modport slave (
        input  start, in_valid, in_pix,
        output win_valid, frame_done, out_row, out_col,
        output x0_0, x0_1, x0_2, x1_0, x1_1, x1_2, x2_0, x2_1, x2_2
    );
endinterface

// File: rtl/window3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3-column shift window,
// emitting valid-padded windows with registered taps, position and frame-done strobe.
module window3x3_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic         clk,
    input  logic         resetn,
    window3x3_if.slave   bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic signed [9:0]   r_lb0 [IMG_W];
    logic signed [9:0]   r_lb1 [IMG_W];
    logic signed [9:0]   r_win [3][3];

    logic [CW-1:0]       w_col;
    logic [RW-1:0]       w_row;
    logic signed [9:0]   w_new [3];
    logic                w_accept;
    logic                w_emit;
    logic                w_last;

    // A start pulse repositions the incoming pixel to (0,0) in the same cycle
    assign w_col    = bus.start ? '0 : r_col;
    assign w_row    = bus.start ? '0 : r_row;
    assign w_accept = bus.in_valid;
    assign w_new[0] = r_lb0[w_col];
    assign w_new[1] = r_lb1[w_col];
    assign w_new[2] = bus.in_pix;
    assign w_emit   = w_accept && !bus.start && (w_row >= ROW_MIN) && (w_col >= COL_MIN);
    assign w_last   = (w_row == ROW_LAST) && (w_col == COL_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end else if (bus.start) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // Line buffers carry no reset; row/col gating keeps stale entries out of windows
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= bus.in_pix;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[j][i] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_win[0][i] <= r_win[1][i];
                r_win[1][i] <= r_win[2][i];
                r_win[2][i] <= w_new[i];
            end
        end
    end

    // Output taps load only on an emitted window so they hold between windows
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.x0_0 <= '0; bus.x0_1 <= '0; bus.x0_2 <= '0;
            bus.x1_0 <= '0; bus.x1_1 <= '0; bus.x1_2 <= '0;
            bus.x2_0 <= '0; bus.x2_1 <= '0; bus.x2_2 <= '0;
        end else begin
            bus.win_valid  <= w_emit;
            bus.frame_done <= w_emit && w_last;
            if (w_emit) begin
                bus.out_row <= w_row;
                bus.out_col <= w_col;
                bus.x0_0 <= r_win[1][0];
                bus.x0_1 <= r_win[1][1];
                bus.x0_2 <= r_win[1][2];
                bus.x1_0 <= r_win[2][0];
                bus.x1_1 <= r_win[2][1];
                bus.x1_2 <= r_win[2][2];
                bus.x2_0 <= w_new[0];
                bus.x2_1 <= w_new[1];
                bus.x2_2 <= w_new[2];
            end
        end
    end

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 5x4 frame, comparing every cycle
// against a frame-array reference model that cuts windows straight from the image.
module tb_window3x3_gen;
    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int BW    = 2 + RW + CW + 90;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    window3x3_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

    window3x3_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the frame as a 2D image plus the raster position
    logic signed [9:0] img [IMG_H][IMG_W];
    int                mRow;
    int                mCol;
    logic              expValid;
    logic              expDone;
    logic [RW-1:0]     expRow;
    logic [CW-1:0]     expCol;
    logic [89:0]       expTaps;

    function automatic logic [89:0] tapsOf();
        return {bus.x2_2, bus.x2_1, bus.x2_0, bus.x1_2, bus.x1_1, bus.x1_0,
                bus.x0_2, bus.x0_1, bus.x0_0};
    endfunction

    function automatic logic [BW-1:0] obsBundle();
        return {bus.win_valid, bus.frame_done, bus.out_row, bus.out_col, tapsOf()};
    endfunction

    function automatic logic [BW-1:0] expBundle();
        return {expValid, expDone, expRow, expCol, expTaps};
    endfunction

    task automatic modelReset();
        mRow = 0; mCol = 0;
        expValid = 1'b0; expDone = 1'b0;
        expRow = '0; expCol = '0; expTaps = '0;
    endtask

    // Drive one cycle, update the reference model, sample #1 after the edge
    task automatic applyStimulus(input logic v, input logic signed [9:0] p, input logic s);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_pix   = p;
        bus.start    = s;
        if (s) begin
            mRow = 0; mCol = 0;
        end
        expValid = 1'b0;
        expDone  = 1'b0;
        if (v) begin
            img[mRow][mCol] = p;
            if (mRow >= 2 && mCol >= 2) begin
                expValid = 1'b1;
                expDone  = (mRow == IMG_H - 1) && (mCol == IMG_W - 1);
                expRow   = RW'(mRow);
                expCol   = CW'(mCol);
                for (int j = 0; j < 3; j++)
                    for (int i = 0; i < 3; i++)
                        expTaps[(j*3+i)*10 +: 10] = img[mRow-2+i][mCol-2+j];
            end
            mCol++;
            if (mCol == IMG_W) begin
                mCol = 0;
                mRow = (mRow + 1) % IMG_H;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_pix = '0;
        #2 resetn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obsBundle() !== expBundle()) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", obsBundle(), expBundle());
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        int nWin = 0;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                applyStimulus(1'b1, 10'(16*r + c), 1'b0);
                checks++;
                if (obsBundle() !== expBundle()) begin
                    failures++;
                    $display("[TB] FAIL basic_cycle r=%0d c=%0d got=%h exp=%h", r, c, obsBundle(), expBundle());
                end
                if (bus.win_valid) begin
                    nWin++;
                    if (nWin == 1) begin
                        checks++;
                        if ({bus.out_row, bus.out_col, bus.x0_0, bus.x1_1, bus.x2_2, bus.x2_0, bus.x0_2} !==
                            {2'd2, 3'd2, 10'sd0, 10'sd17, 10'sd34, 10'sd2, 10'sd32}) begin
                            failures++;
                            $display("[TB] FAIL basic_first_window got row=%0d col=%0d x00=%0d x11=%0d x22=%0d x20=%0d x02=%0d exp 2,2,0,17,34,2,32",
                                     bus.out_row, bus.out_col, bus.x0_0, bus.x1_1, bus.x2_2, bus.x2_0, bus.x0_2);
                        end
                    end
                end
                if (r == IMG_H - 1 && c == IMG_W - 1) begin
                    checks++;
                    if ({bus.win_valid, bus.frame_done, bus.out_row, bus.out_col, bus.x2_2} !==
                        {1'b1, 1'b1, 2'd3, 3'd4, 10'sd52}) begin
                        failures++;
                        $display("[TB] FAIL basic_last_window got v=%0b done=%0b row=%0d col=%0d x22=%0d exp 1,1,3,4,52",
                                 bus.win_valid, bus.frame_done, bus.out_row, bus.out_col, bus.x2_2);
                    end
                end
            end
        end
        checks++;
        if (nWin != 6) begin
            failures++;
            $display("[TB] FAIL basic_window_count got=%0d exp=6", nWin);
        end
    endtask

    task automatic test_gapped();
        int nWin = 0;
        int idx  = 0;
        logic v;
        for (int cyc = 0; cyc < 400 && idx < IMG_W*IMG_H; cyc++) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(v, v ? 10'(16*(idx/IMG_W) + idx%IMG_W) : 10'($urandom), 1'b0);
            checks++;
            if (obsBundle() !== expBundle()) begin
                failures++;
                $display("[TB] FAIL gapped_cycle cyc=%0d got=%h exp=%h", cyc, obsBundle(), expBundle());
            end
            if (!v && bus.win_valid) begin
                failures++;
                $display("[TB] FAIL gapped_idle_strobe cyc=%0d got win_valid=1 exp=0", cyc);
            end
            if (bus.win_valid) nWin++;
            if (v) idx++;
        end
        checks++;
        if (idx != IMG_W*IMG_H || nWin != 6) begin
            failures++;
            $display("[TB] FAIL gapped_window_count got pixels=%0d windows=%0d exp 20,6", idx, nWin);
        end
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int nWin = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < IMG_H; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    applyStimulus(1'b1, 10'(100*f + 16*r + c), 1'b0);
                    checks++;
                    if (obsBundle() !== expBundle()) begin
                        failures++;
                        $display("[TB] FAIL b2b_cycle f=%0d r=%0d c=%0d got=%h exp=%h", f, r, c, obsBundle(), expBundle());
                    end
                    if (bus.win_valid) begin
                        nWin++;
                        if (nWin == 7) begin
                            checks++;
                            if ({bus.x0_0, bus.x2_2} !== {10'sd100, 10'sd134}) begin
                                failures++;
                                $display("[TB] FAIL b2b_frame2_first got x00=%0d x22=%0d exp 100,134", bus.x0_0, bus.x2_2);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (nWin != 12) begin
            failures++;
            $display("[TB] FAIL b2b_window_count got=%0d exp=12", nWin);
        end
    endtask

    task automatic test_restart();
        int nWin = 0;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 10'($urandom), 1'b0);
            checks++;
            if (obsBundle() !== expBundle()) begin
                failures++;
                $display("[TB] FAIL restart_pre k=%0d got=%h exp=%h", k, obsBundle(), expBundle());
            end
        end
        for (int k = 0; k < IMG_W*IMG_H; k++) begin
            applyStimulus(1'b1, 10'(16*(k/IMG_W) + k%IMG_W), (k == 0));
            checks++;
            if (obsBundle() !== expBundle()) begin
                failures++;
                $display("[TB] FAIL restart_cycle k=%0d got=%h exp=%h", k, obsBundle(), expBundle());
            end
            if (bus.win_valid) nWin++;
        end
        checks++;
        if (nWin != 6) begin
            failures++;
            $display("[TB] FAIL restart_window_count got=%0d exp=6", nWin);
        end
    endtask

    task automatic test_midreset();
        int nWin = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 10'($urandom), 1'b0);
        end
        bus.in_valid = 1'b0;
        #2 resetn = 1'b0;
        modelReset();
        #1;
        checks++;
        if (obsBundle() !== expBundle()) begin
            failures++;
            $display("[TB] FAIL midreset_async got=%h exp=%h", obsBundle(), expBundle());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obsBundle() !== expBundle()) begin
            failures++;
            $display("[TB] FAIL midreset_held got=%h exp=%h", obsBundle(), expBundle());
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < IMG_W*IMG_H; k++) begin
            applyStimulus(1'b1, 10'(16*(k/IMG_W) + k%IMG_W), 1'b0);
            checks++;
            if (obsBundle() !== expBundle()) begin
                failures++;
                $display("[TB] FAIL midreset_cycle k=%0d got=%h exp=%h", k, obsBundle(), expBundle());
            end
            if (bus.win_valid) nWin++;
        end
        checks++;
        if (nWin != 6) begin
            failures++;
            $display("[TB] FAIL midreset_window_count got=%0d exp=6", nWin);
        end
    endtask

    task automatic test_extremes();
        logic signed [9:0] pLo;
        logic signed [9:0] pHi;
        int nWin = 0;
        pLo = 10'h200;
        pHi = 10'h1FF;
        for (int k = 0; k < IMG_W*IMG_H; k++) begin
            applyStimulus(1'b1, (k % 2 == 0) ? pLo : pHi, 1'b0);
            checks++;
            if (obsBundle() !== expBundle()) begin
                failures++;
                $display("[TB] FAIL extremes_cycle k=%0d got=%h exp=%h", k, obsBundle(), expBundle());
            end
            if (bus.win_valid) begin
                nWin++;
                if (nWin == 1) begin
                    checks++;
                    if (bus.x0_0 !== pLo || bus.x1_0 !== pHi || bus.x2_2 !== pLo ||
                        $signed(bus.x0_0) != -512 || $signed(bus.x1_0) != 511) begin
                        failures++;
                        $display("[TB] FAIL extremes_sign got x00=%0d x10=%0d x22=%0d exp -512,511,-512",
                                 bus.x0_0, bus.x1_0, bus.x2_2);
                    end
                end
            end
        end
        checks++;
        if (nWin != 6) begin
            failures++;
            $display("[TB] FAIL extremes_window_count got=%0d exp=6", nWin);
        end
    endtask

    // Scenario sequence; every scenario starts from row 0, col 0
    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pix   = '0;
        modelReset();
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_restart();
        test_midreset();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3x3 window generator that feeds the `filter3x3` convolution stage. It accepts one signed 10-bit pixel per valid cycle in raster order and keeps two line buffers plus a 3x3 shift window. It presents the nine window taps `x{j}_{i}` together with a one-cycle `win_valid` strobe. Windows use valid-padding only, giving (IMG_W-2)x(IMG_H-2) windows per frame. It sits between the pixel source (input stream or previous layer output) and the filter, whose inputs it drives directly.

## Interface
- `IMG_W`, default 32: pixels per row; legal range >= 3.
- `IMG_H`, default 32: rows per frame; legal range >= 3.
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse: abort any partial frame and restart the counters at (row 0, col 0).
- `in_valid`  in  1  `in_pix` is valid this cycle; every valid pixel is accepted (no backpressure).
- `in_pix`  in  10  signed pixel.
- `win_valid`  out  1  window taps valid this cycle (single-cycle strobe per window).
- `x{j}_{i}`, j,i in 0..2  out  10 each  signed window taps.
  - j = column: 0 is leftmost/oldest, 2 is newest.
  - i = row: 0 is top/oldest, 2 is current row.
- `out_row`  out  clog2(IMG_H)  row of the window's bottom-right pixel.
- `out_col`  out  clog2(IMG_W)  column of the window's bottom-right pixel.
- `frame_done`  out  1  one-cycle pulse with the last window of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `in_valid`.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 at IMG_H-1, so back-to-back frames need no `start`.
- Line buffer LB1 holds the previous row; LB0 holds the row before it. Each is IMG_W x 10 bits, implemented as a shift register or a dual-port RAM.
- On each accepted pixel at column c:
  - Column c of LB0 takes the old LB1[c].
  - LB1[c] takes `in_pix`.
  - The window shifts left: column j takes column j+1 for j = 0,1.
  - The new column 2 is {LB0[c], LB1[c], in_pix}, using the pre-update line-buffer values, for rows 0, 1, 2.
- A window is emitted when an accepted pixel has row >= 2 and col >= 2.
  - The window taps are pixels (row-2+i, col-2+j).
  - `win_valid` = 1, and `out_row`/`out_col` = (row, col) of that pixel.
- `frame_done` = 1 together with the window whose pixel is (IMG_H-1, IMG_W-1).
- Windows at col 0 and 1 are never emitted. Window columns are not cleared at a row wrap; the col >= 2 rule alone guarantees correctness.
- Data passes through bit-exact; no arithmetic is applied to pixel values.
- With `in_valid` low, every counter, buffer and tap holds its value, and `win_valid`/`frame_done` are 0.
- `start`:
  - Sets row = col = 0. Line buffers and taps are not cleared; stale data is never emitted because of the row/col gating.
  - If `start` and `in_valid` are high in the same cycle, the pixel is accepted as (0,0).
  - No window is emitted in the `start` cycle.

## Timing
- Latency: a window appears one cycle after the clock edge that accepts its bottom-right pixel. All outputs are registered.
- Throughput: one window per accepted pixel in the emitting region; sustains `in_valid` = 1 on every cycle.
- Reset values:
  - `win_valid` = 0, `frame_done` = 0.
  - All `x{j}_{i}` = 0, `out_row` = 0, `out_col` = 0.
  - Internal row = col = 0; line-buffer contents are don't-care.
- `resetn` asserted mid-frame clears everything immediately (asynchronously). The first pixel accepted after release is (0,0).
- Taps, `out_row` and `out_col` hold their last window value while `win_valid` = 0.

## Test plan
- **Basic window**
  - Stimulus: IMG_W=5, IMG_H=4, continuous `in_valid`, pixel = 16*row + col.
  - Response: the first `win_valid` comes one cycle after pixel 34 with x0_0=0, x1_1=17, x2_2=34, x2_0=2, x0_2=32.
  - Response: 6 windows total; the last has out_row=3, out_col=4, x2_2=52 and `frame_done` = 1.
- **Gapped input**
  - Stimulus: same frame with `in_valid` toggling randomly at about 50%.
  - Response: identical window sequence and tap values; `win_valid` is never high in a cycle after a non-accepted input.
- **Back-to-back frames**
  - Stimulus: two frames streamed without `start`, the second with pixel = 100 + 16*row + col.
  - Response: 12 windows; the first window of frame 2 has x0_0=100, x2_2=134.
- **Mid-frame restart**
  - Stimulus: `start` after 9 pixels, coincident with a valid pixel of value 0, then a full frame.
  - Response: exactly 6 windows, all matching the basic-window test; no window comes from pre-`start` data.
- **Mid-frame reset**
  - Stimulus: `resetn` pulsed low during row 3.
  - Response: all outputs are 0 while reset is low; after release a full frame produces the 6 expected windows.
- **Extremes**
  - Stimulus: pixels alternating -512 and 511.
  - Response: taps reproduce the exact signed values with no sign corruption.
